// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the fetch-stage PC sequencer.
//   state_t    : controller states (IDLE, BOOT, RUN, REDIR_PEND)
//   pc_src_t   : next-PC source select codes
//   XLEN       : PC width in bits
`timescale 1ns/1ps
package pc_seq_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BOOT       = 2'd1,
    RUN        = 2'd2,
    REDIR_PEND = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_VEC  = 2'd0,  // reset vector
    SRC_SEQ  = 2'd1,  // pc_cur + step
    SRC_BR   = 2'd2,  // live branch target
    SRC_PEND = 2'd3   // captured (deferred) branch target
  } pc_src_t;

endpackage

// File: rtl/pc_seq_perf_cnt.sv
// pc_seq_perf_cnt: pair of 32-bit saturating event counters.
// Only instantiated when PC_SEQ_PERF_EN is defined.
// Ports:
//   clk_i, rst_i       : clock, async active-low reset
//   clr_i              : synchronous clear (dominates increments)
//   stall_inc_i        : count one stall cycle
//   redir_inc_i        : count one applied redirect
//   stall_cycles_o     : stall cycle count
//   redirect_cnt_o     : redirect count
`timescale 1ns/1ps
module pc_seq_perf_cnt
  import pc_seq_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            stall_inc_i,
  input  logic            redir_inc_i,
  output logic [XLEN-1:0] stall_cycles_o,
  output logic [XLEN-1:0] redirect_cnt_o
);

  logic [XLEN-1:0] r_stall_cnt;
  logic [XLEN-1:0] r_redir_cnt;

  // Stall cycle counter, holds at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= 32'd0;
    end else if (clr_i) begin
      r_stall_cnt <= 32'd0;
    end else if (stall_inc_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // Redirect counter, holds at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_redir_cnt <= 32'd0;
    end else if (clr_i) begin
      r_redir_cnt <= 32'd0;
    end else if (redir_inc_i && (r_redir_cnt != 32'hFFFF_FFFF)) begin
      r_redir_cnt <= r_redir_cnt + 32'd1;
    end else begin
      r_redir_cnt <= r_redir_cnt;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
  assign redirect_cnt_o = r_redir_cnt;

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch-stage PC sequencing controller.
// Chooses the next PC (boot vector, branch target, deferred target or
// sequential), generates the PC write enable and the IF/ID flush.
// Optional feature macro: PC_SEQ_PERF_EN (adds stall/redirect counters).
// Ports:
//   clk_i, rst_i          : clock, async active-low reset
//   start_i               : run enable (low -> IDLE)
//   cpu_stall_i           : cache stall, blocks every PC write
//   hazard_stall_i        : load-use stall (overridden by a redirect)
//   branch_taken_i        : ID-stage taken branch/jump
//   branch_target_i       : redirect target
//   pc_cur_i              : current PC register value
//   pc_next_o             : PC register D input
//   pc_write_o            : PC register write enable
//   flush_o               : IF/ID flush, one cycle per applied redirect
//   running_o             : high in BOOT/RUN/REDIR_PEND
//   stall_cycles_o, redirect_cnt_o : perf counters (PC_SEQ_PERF_EN only)
`timescale 1ns/1ps
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            cpu_stall_i,
  input  logic            hazard_stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] pc_cur_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_write_o,
  output logic            flush_o,
`ifdef PC_SEQ_PERF_EN
  output logic [XLEN-1:0] stall_cycles_o,
  output logic [XLEN-1:0] redirect_cnt_o,
`endif
  output logic            running_o
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pend_tgt;
  pc_src_t         w_src;
  logic            w_pend_cap;
  logic            w_pc_write;
  logic            w_flush;
  logic            w_running;

  // State and deferred-target registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_pend_tgt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pend_cap) begin
        r_pend_tgt <= branch_target_i;
      end else begin
        r_pend_tgt <= r_pend_tgt;
      end
    end
  end

  // Next-state, source select and control outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_src       = SRC_VEC;
    w_pend_cap  = 1'b0;
    w_pc_write  = 1'b0;
    w_flush     = 1'b0;
    w_running   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = BOOT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BOOT: begin
        w_running = 1'b1;
        w_src     = SRC_VEC;
        if (!start_i) begin
          w_state_nxt = IDLE;
        end else if (!cpu_stall_i) begin
          w_pc_write  = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = BOOT;
        end
      end
      RUN: begin
        w_running = 1'b1;
        w_src     = branch_taken_i ? SRC_BR : SRC_SEQ;
        if (!start_i) begin
          w_state_nxt = IDLE;
        end else if (cpu_stall_i) begin
          // A redirect arriving under a cache stall is parked until the stall drops.
          if (branch_taken_i) begin
            w_pend_cap  = 1'b1;
            w_state_nxt = REDIR_PEND;
          end else begin
            w_state_nxt = RUN;
          end
        end else if (branch_taken_i) begin
          // Redirect wins over a load-use stall: the stalled instruction is flushed anyway.
          w_pc_write = 1'b1;
          w_flush    = 1'b1;
        end else begin
          w_pc_write = ~hazard_stall_i;
        end
      end
      REDIR_PEND: begin
        w_running = 1'b1;
        w_src     = SRC_PEND;
        if (!start_i) begin
          w_state_nxt = IDLE;
        end else if (!cpu_stall_i) begin
          w_pc_write  = 1'b1;
          w_flush     = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = REDIR_PEND;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Next-PC mux; sequential path wraps naturally at 32 bits.
  always_comb begin
    case (w_src)
      SRC_VEC:  pc_next_o = RESET_VECTOR;
      SRC_SEQ:  pc_next_o = pc_cur_i + PC_STEP;
      SRC_BR:   pc_next_o = branch_target_i;
      SRC_PEND: pc_next_o = r_pend_tgt;
      default:  pc_next_o = RESET_VECTOR;
    endcase
  end

  assign pc_write_o = w_pc_write;
  assign flush_o    = w_flush;
  assign running_o  = w_running;

`ifdef PC_SEQ_PERF_EN
  logic w_perf_clr;

  // Counters clear on the edge that enters IDLE.
  assign w_perf_clr = (w_state_nxt == IDLE);

  pc_seq_perf_cnt u_perf (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (w_perf_clr),
    .stall_inc_i    (w_running & ~w_pc_write),
    .redir_inc_i    (w_flush),
    .stall_cycles_o (stall_cycles_o),
    .redirect_cnt_o (redirect_cnt_o)
  );
`endif

endmodule
